// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register family (PISO / SISO / SIPO).
// Holds the two-state FSM encoding and a constant-width helper.
package shift_reg_pkg;

  // Two-state frame FSM used by all serial blocks of the family.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Ceiling log2 for sizing counters at elaboration time; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage : shift_reg_pkg

// File: rtl/piso_serializer_if.sv
// Load handshake and serial frame output of the PISO serializer.
// The slave side is the serializer; the master side is the word source
// that also observes the serial stream.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             frame_done;

  modport slave (
    input  din,
    input  load_valid,
    output load_ready,
    output sout,
    output sout_valid,
    output frame_start,
    output frame_done
  );

  modport master (
    output din,
    output load_valid,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  frame_start,
    input  frame_done
  );

endinterface : piso_serializer_if

// File: rtl/piso_shift_core.sv
// Loadable shift register. The outgoing bit is taken straight from a flop,
// and vacated positions are zero-filled, so a register that has shifted out
// a whole word reads back as all zeros and drives sout low.
module piso_shift_core #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shifted;

  // Next register value for one shift step, moving toward the output end.
  always_comb begin
    // NOTE: a default assignment on every path keeps always_comb latch-free.
    w_shifted = r_shreg;
    if (MSB_FIRST) begin
      w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin
      w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  end

  // Shift register: load has priority over shift.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the data register is reset too, so an aborted frame leaves no residue on sout.
    if (!reset) begin
      r_shreg <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments for all flop updates avoid ordering races.
      r_shreg <= din;
    end else if (shift) begin
      r_shreg <= w_shifted;
    end
  end

  assign sout = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

endmodule : piso_shift_core

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter. Accepts a WIDTH-bit word over a
// valid/ready handshake and sends it one bit per clock with frame markers.
// A new word can be taken on the last bit of a frame, so frames run
// back-to-back without a gap.
module piso_serializer
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  piso_serializer_if.slave   bus
);

  localparam int              CNT_W   = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(WIDTH - 2);

  state_e           r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_sout_valid;
  logic             r_frame_start;
  logic             r_frame_done;

  logic             w_load_ready;
  logic             w_accept;
  logic             w_shift;
  logic             w_core_sout;

  // Ready when idle, or on the last bit of a frame to allow a gapless reload.
  assign w_load_ready = (r_state == ST_IDLE) || (r_bit_cnt == LAST);
  assign w_accept     = bus.load_valid && w_load_ready;
  assign w_shift      = (r_state == ST_SHIFT) && !w_accept;

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (w_accept),
    .shift (w_shift),
    .din   (bus.din),
    .sout  (w_core_sout)
  );

  // Frame FSM with bit counter and registered frame flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_sout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state       <= ST_SHIFT;
            r_bit_cnt     <= '0;
            r_sout_valid  <= 1'b1;
            r_frame_start <= 1'b1;
            r_frame_done  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (r_bit_cnt == LAST) begin
            if (w_accept) begin
              // Next word follows immediately.
              r_bit_cnt     <= '0;
              r_sout_valid  <= 1'b1;
              r_frame_start <= 1'b1;
              r_frame_done  <= 1'b0;
            end else begin
              r_state       <= ST_IDLE;
              r_bit_cnt     <= '0;
              r_sout_valid  <= 1'b0;
              r_frame_start <= 1'b0;
              r_frame_done  <= 1'b0;
            end
          end else begin
            r_bit_cnt     <= r_bit_cnt + 1'b1;
            r_sout_valid  <= 1'b1;
            r_frame_start <= 1'b0;
            r_frame_done  <= (r_bit_cnt == LAST_M1);
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_bit_cnt     <= '0;
          r_sout_valid  <= 1'b0;
          r_frame_start <= 1'b0;
          r_frame_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready  = w_load_ready;
  assign bus.sout        = w_core_sout;
  assign bus.sout_valid  = r_sout_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_done  = r_frame_done;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first
// instance, WIDTH=4, with hand-computed expected bit streams.
module tb_piso_serializer;

  localparam int WIDTH = 4;

  logic clk;
  logic reset;

  int n_compared   = 0;
  int n_mismatched = 0;

  piso_serializer_if #(.WIDTH(WIDTH)) bus_msb ();
  piso_serializer_if #(.WIDTH(WIDTH)) bus_lsb ();

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_msb)
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every output of one instance (sel 0 = MSB-first, 1 = LSB-first).
  task automatic expect_out(input string tag, input int sel, input logic e_sout,
                            input logic e_valid, input logic e_start,
                            input logic e_done, input logic e_ready);
    if (sel == 0) begin
      check({tag, ".sout"},        32'(bus_msb.sout),        32'(e_sout));
      check({tag, ".sout_valid"},  32'(bus_msb.sout_valid),  32'(e_valid));
      check({tag, ".frame_start"}, 32'(bus_msb.frame_start), 32'(e_start));
      check({tag, ".frame_done"},  32'(bus_msb.frame_done),  32'(e_done));
      check({tag, ".load_ready"},  32'(bus_msb.load_ready),  32'(e_ready));
    end else begin
      check({tag, ".sout"},        32'(bus_lsb.sout),        32'(e_sout));
      check({tag, ".sout_valid"},  32'(bus_lsb.sout_valid),  32'(e_valid));
      check({tag, ".frame_start"}, 32'(bus_lsb.frame_start), 32'(e_start));
      check({tag, ".frame_done"},  32'(bus_lsb.frame_done),  32'(e_done));
      check({tag, ".load_ready"},  32'(bus_lsb.load_ready),  32'(e_ready));
    end
  endtask

  // Send one word on an idle instance. exp_seq[3] is the bit expected in
  // cycle 1, exp_seq[0] the bit in cycle 4. Returns positioned in cycle 5.
  task automatic send_frame(input string tag, input int sel, input logic [3:0] word,
                            input logic [3:0] exp_seq);
    if (sel == 0) begin
      bus_msb.din = word; bus_msb.load_valid = 1'b1;
    end else begin
      bus_lsb.din = word; bus_lsb.load_valid = 1'b1;
    end
    tick();
    bus_msb.load_valid = 1'b0; bus_msb.din = '0;
    bus_lsb.load_valid = 1'b0; bus_lsb.din = '0;
    for (int k = 0; k < 4; k++) begin
      expect_out($sformatf("%s.c%0d", tag, k + 1), sel, exp_seq[3-k], 1'b1,
                 k == 0, k == 3, k == 3);
      tick();
    end
  endtask

  initial begin
    logic [7:0] b2b_seq;

    reset = 1'b0;
    bus_msb.din = '0; bus_msb.load_valid = 1'b0;
    bus_lsb.din = '0; bus_lsb.load_valid = 1'b0;
    tick();
    tick();
    expect_out("por", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("por", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();

    // In IDLE a changing din with no valid must not disturb anything.
    bus_msb.din = 4'hF;
    tick();
    bus_msb.din = 4'h5;
    tick();
    expect_out("idle_din", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus_msb.din = '0;

    // Test 1: reset mid-run while a loaded word is being sent.
    bus_msb.din = 4'b1011; bus_msb.load_valid = 1'b1;
    tick();
    bus_msb.load_valid = 1'b0;
    tick();
    bus_msb.din = 4'hF; bus_msb.load_valid = 1'b1;
    reset = 1'b0;
    #1;
    expect_out("t1_async", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    expect_out("t1_held", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    bus_msb.load_valid = 1'b0; bus_msb.din = '0;
    reset = 1'b1;
    tick();
    expect_out("t1_release", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Test 2: 1001 MSB-first -> 1,0,0,1 then IDLE.
    send_frame("t2", 0, 4'b1001, 4'b1001);
    expect_out("t2.c5", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Test 3: 1100 then 0011 held valid -> 1,1,0,0,0,0,1,1 gapless.
    b2b_seq = 8'b1100_0011;
    bus_msb.din = 4'b1100; bus_msb.load_valid = 1'b1;
    tick();
    bus_msb.din = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      expect_out($sformatf("t3.c%0d", k + 1), 0, b2b_seq[7-k], 1'b1,
                 (k == 0) || (k == 4), (k == 3) || (k == 7), (k == 3) || (k == 7));
      tick();
      if (k == 3) begin
        bus_msb.load_valid = 1'b0; bus_msb.din = '0;
      end
    end
    expect_out("t3.c9", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Test 4: LSB-first 0001 -> 1,0,0,0.
    send_frame("t4", 1, 4'b0001, 4'b1000);
    expect_out("t4.c5", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Test 5: offer 4'hA during cycle 2 of a 0111 frame; it must be ignored.
    bus_msb.din = 4'b0111; bus_msb.load_valid = 1'b1;
    tick();
    bus_msb.load_valid = 1'b0; bus_msb.din = '0;
    expect_out("t5.c1", 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    bus_msb.din = 4'hA; bus_msb.load_valid = 1'b1;
    expect_out("t5.c2", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    bus_msb.load_valid = 1'b0; bus_msb.din = '0;
    expect_out("t5.c3", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("t5.c4", 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    expect_out("t5.c5", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("t5.c6", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Test 6: abort a 1111 frame in cycle 2, then send 0110 cleanly.
    bus_msb.din = 4'b1111; bus_msb.load_valid = 1'b1;
    tick();
    bus_msb.load_valid = 1'b0; bus_msb.din = '0;
    tick();
    expect_out("t6.pre", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    expect_out("t6.abort", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    send_frame("t6", 0, 4'b0110, 4'b0110);
    expect_out("t6.c5", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_piso_serializer
